// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator (800x600 @ 60 Hz, 40 MHz pixel clock).
// Every output is registered and derived from the next counter value, so flags never lag the counters.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_TOTAL  = 1056,
    parameter int H_SYNC_S = 840,
    parameter int H_SYNC_W = 128,
    parameter int V_ACTIVE = 600,
    parameter int V_TOTAL  = 628,
    parameter int V_SYNC_S = 601,
    parameter int V_SYNC_W = 4,
    parameter int FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [10:0]       hcount,
    output logic [10:0]       vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              hblnk,
    output logic              vblnk,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_S   = 12'(H_SYNC_S);
    localparam logic [11:0] HS_E   = 12'(H_SYNC_S + H_SYNC_W);
    localparam logic [11:0] VS_S   = 12'(V_SYNC_S);
    localparam logic [11:0] VS_E   = 12'(V_SYNC_S + V_SYNC_W);

    if ((H_SYNC_S + H_SYNC_W > H_TOTAL) || (V_SYNC_S + V_SYNC_W > V_TOTAL)) begin : g_bad_params
        $error("vga_timing: sync window extends past the line or frame total");
    end

    logic [10:0]       hcount_q, hcount_d;
    logic [10:0]       vcount_q, vcount_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              hblnk_q, hblnk_d;
    logic              vblnk_q, vblnk_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_cnt_d   = frame_cnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (en) begin
            if (hcount_q == H_LAST) begin
                hcount_d     = 11'd0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = 11'd0;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
                end else begin
                    vcount_d = vcount_q + 11'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
        // Strobes follow the value the counters are about to take.
        hsync_d = ({1'b0, hcount_d} >= HS_S) && ({1'b0, hcount_d} < HS_E);
        vsync_d = ({1'b0, vcount_d} >= VS_S) && ({1'b0, vcount_d} < VS_E);
        hblnk_d = ({1'b0, hcount_d} >= H_ACT);
        vblnk_d = ({1'b0, vcount_d} >= V_ACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance for the 800x600 line timing and a
// shrunken-raster instance for frame wrap, stalls, frame counter wrap and mid-frame reset.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_d = 1'b0, en_d = 1'b1;
    logic rst_n_s = 1'b0, en_s = 1'b1;

    logic [10:0] hcount_d, vcount_d, hcount_s, vcount_s;
    logic        hsync_d, vsync_d, hblnk_d, vblnk_d, line_start_d, frame_start_d;
    logic        hsync_s, vsync_s, hblnk_s, vblnk_s, line_start_s, frame_start_s;
    logic [15:0] frame_cnt_d;
    logic [1:0]  frame_cnt_s;

    vga_timing dut (
        .clk(clk), .rst_n(rst_n_d), .en(en_d),
        .hcount(hcount_d), .vcount(vcount_d), .hsync(hsync_d), .vsync(vsync_d),
        .hblnk(hblnk_d), .vblnk(vblnk_d), .line_start(line_start_d),
        .frame_start(frame_start_d), .frame_cnt(frame_cnt_d)
    );

    // Small raster: 16 clocks x 9 lines, hsync 11..13, vsync lines 7..8, 2-bit frame counter.
    vga_timing #(
        .H_ACTIVE(10), .H_TOTAL(16), .H_SYNC_S(11), .H_SYNC_W(3),
        .V_ACTIVE(6),  .V_TOTAL(9),  .V_SYNC_S(7),  .V_SYNC_W(2), .FCNT_W(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n_s), .en(en_s),
        .hcount(hcount_s), .vcount(vcount_s), .hsync(hsync_s), .vsync(vsync_s),
        .hblnk(hblnk_s), .vblnk(vblnk_s), .line_start(line_start_s),
        .frame_start(frame_start_s), .frame_cnt(frame_cnt_s)
    );

    // {small_sel, hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start, frame_cnt}
    logic [44:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int vec_idx = 0;

    function automatic logic [44:0] mk(input bit sm, input int h, input int v, input int fc,
                                       input bit ls, input bit fs);
        int ha, hss, hse, va, vss, vse;
        logic hs, vs, hb, vb;
        if (sm) begin
            ha = 10; hss = 11; hse = 14; va = 6; vss = 7; vse = 9;
        end else begin
            ha = 800; hss = 840; hse = 968; va = 600; vss = 601; vse = 605;
        end
        hs = (h >= hss) && (h < hse);
        vs = (v >= vss) && (v < vse);
        hb = (h >= ha);
        vb = (v >= va);
        return {sm, 11'(h), 11'(v), hs, vs, hb, vb, ls, fs, 16'(fc)};
    endfunction

    task automatic expect_v(input logic [44:0] e);
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    logic [44:0] mon_e, mon_a;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e[44])
                mon_a = {1'b1, hcount_s, vcount_s, hsync_s, vsync_s, hblnk_s, vblnk_s,
                         line_start_s, frame_start_s, 14'd0, frame_cnt_s};
            else
                mon_a = {1'b0, hcount_d, vcount_d, hsync_d, vsync_d, hblnk_d, vblnk_d,
                         line_start_d, frame_start_d, frame_cnt_d};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL vec%0d got h=%0d v=%0d flags=%b fc=%0d exp h=%0d v=%0d flags=%b fc=%0d",
                         vec_idx, mon_a[43:33], mon_a[32:22], mon_a[21:16], mon_a[15:0],
                         mon_e[43:33], mon_e[32:22], mon_e[21:16], mon_e[15:0]);
            end
            vec_idx++;
        end
    end

    always @(negedge clk) begin
        assert (hcount_d < 11'd1056 && vcount_d < 11'd628 && hcount_s < 11'd16 && vcount_s < 11'd9)
        else begin
            errors++;
            $display("FAIL range hd=%0d vd=%0d hs=%0d vs=%0d", hcount_d, vcount_d, hcount_s, vcount_s);
        end
    end

    int hb_cnt, hs_cnt, ls_cnt;

    initial begin
        // Full-size raster: reset, then line boundaries.
        step(3);
        expect_v(mk(0, 0, 0, 0, 0, 0));
        step(1);
        rst_n_d = 1'b1;
        step(1);   expect_v(mk(0, 1, 0, 0, 0, 0));
        step(798); expect_v(mk(0, 799, 0, 0, 0, 0));
        step(1);   expect_v(mk(0, 800, 0, 0, 0, 0));
        step(39);  expect_v(mk(0, 839, 0, 0, 0, 0));
        step(1);   expect_v(mk(0, 840, 0, 0, 0, 0));
        step(127); expect_v(mk(0, 967, 0, 0, 0, 0));
        step(1);   expect_v(mk(0, 968, 0, 0, 0, 0));
        step(87);  expect_v(mk(0, 1055, 0, 0, 0, 0));
        step(1);   expect_v(mk(0, 0, 1, 0, 1, 0));
        step(1);   expect_v(mk(0, 1, 1, 0, 0, 0));
        hb_cnt = 0; hs_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 1056; i++) begin
            step(1);
            hb_cnt += int'(hblnk_d);
            hs_cnt += int'(hsync_d);
            ls_cnt += int'(line_start_d);
        end
        chk("hblnk_per_line", hb_cnt, 256);
        chk("hsync_per_line", hs_cnt, 128);
        chk("line_start_per_line", ls_cnt, 1);
        en_d = 1'b0;

        // Small raster: held in reset with en=1 the whole time so far.
        expect_v(mk(1, 0, 0, 0, 0, 0));
        rst_n_s = 1'b1;
        step(1);   expect_v(mk(1, 1, 0, 0, 0, 0));
        step(14);  expect_v(mk(1, 15, 0, 0, 0, 0));
        step(1);   expect_v(mk(1, 0, 1, 0, 1, 0));
        step(1);   expect_v(mk(1, 1, 1, 0, 0, 0));
        step(78);  expect_v(mk(1, 15, 5, 0, 0, 0));
        step(1);   expect_v(mk(1, 0, 6, 0, 1, 0));
        step(16);  expect_v(mk(1, 0, 7, 0, 1, 0));
        step(15);  expect_v(mk(1, 15, 7, 0, 0, 0));
        step(1);   expect_v(mk(1, 0, 8, 0, 1, 0));
        step(15);  expect_v(mk(1, 15, 8, 0, 0, 0));
        step(1);   expect_v(mk(1, 0, 0, 1, 1, 1));
        step(1);   expect_v(mk(1, 1, 0, 1, 0, 0));
        step(142); expect_v(mk(1, 15, 8, 1, 0, 0));
        // Stall on the last pixel of the frame.
        en_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1); expect_v(mk(1, 15, 8, 1, 0, 0));
        end
        en_s = 1'b1;
        step(1);   expect_v(mk(1, 0, 0, 2, 1, 1));
        step(1);   expect_v(mk(1, 1, 0, 2, 0, 0));
        step(142); expect_v(mk(1, 15, 8, 2, 0, 0));
        step(1);   expect_v(mk(1, 0, 0, 3, 1, 1));
        step(143); expect_v(mk(1, 15, 8, 3, 0, 0));
        step(1);   expect_v(mk(1, 0, 0, 0, 1, 1));
        // Stall right after the pulses: they must drop, not stretch.
        en_s = 1'b0;
        step(1);   expect_v(mk(1, 0, 0, 0, 0, 0));
        en_s = 1'b1;
        step(1);   expect_v(mk(1, 1, 0, 0, 0, 0));
        step(52);  expect_v(mk(1, 5, 3, 0, 0, 0));
        // Asynchronous reset between clock edges.
        @(negedge clk);
        #1;
        rst_n_s = 1'b0;
        #1;
        chk("async_rst_hcount", int'(hcount_s), 0);
        chk("async_rst_vcount", int'(vcount_s), 0);
        step(2);   expect_v(mk(1, 0, 0, 0, 0, 0));
        rst_n_s = 1'b1;
        expect_v(mk(1, 0, 0, 0, 0, 0));
        step(1);   expect_v(mk(1, 1, 0, 0, 0, 0));
        step(14);  expect_v(mk(1, 15, 0, 0, 0, 0));
        step(1);   expect_v(mk(1, 0, 1, 0, 1, 0));

        step(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
